// File: rtl/load_store_unit.sv
// Load/store unit: turns core load/store requests into word-aligned valid/ready
// bus transfers, formats load data, and flags misaligned or illegal requests.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e      state_q, state_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] rdata_q, rdata_d;

  logic req_any, legal, misaligned, ok;

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Byte/halfword lane select followed by sign or zero extension.
  function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign req_any = mem_read | mem_write;

  always_comb begin
    legal = 1'b0;
    if (mem_read && !mem_write) begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
    end else if (mem_write && !mem_read) begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end
  end

  always_comb begin
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign ok = req_any && legal && !misaligned;

  always_comb begin
    state_d     = state_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    lane_d      = lane_q;
    funct3_d    = funct3_q;
    rdata_d     = rdata_q;
    stall       = 1'b0;
    err         = 1'b0;
    case (state_q)
      IDLE: begin
        if (ok) begin
          stall       = 1'b1;
          bus_we_d    = mem_write;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_be_d    = mem_write ? store_be(funct3, addr[1:0]) : 4'b1111;
          bus_wdata_d = store_data(funct3, wdata);
          lane_d      = addr[1:0];
          funct3_d    = funct3;
          state_d     = REQ;
        end else if (req_any) begin
          err     = 1'b1;
          rdata_d = 32'h0;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_ready) begin
          if (!bus_we_q) rdata_d = load_fmt(bus_rdata, funct3_q, lane_q);
          state_d = DONE;
        end
      end
      // The core consumes the result this cycle; its held request is not reissued.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      lane_q      <= 2'b00;
      funct3_q    <= 3'b000;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      lane_q      <= lane_d;
      funct3_q    <= funct3_d;
      rdata_q     <= rdata_d;
    end
  end

  // Derived from state so an asynchronous reset drops it without an edge.
  assign bus_valid = (state_q == REQ);
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a rule-level access model.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, err;
  logic        bus_valid, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rdata_m = 32'h0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .err(err), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at ~1ns after a rising edge with the unit in IDLE; ends likewise.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rw, input int dly);
    logic        legal, aligned, go;
    int          size;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd, sh;
    logic [7:0]  bb;
    logic [15:0] hh;

    if (wr && !rd)      legal = f3 inside {3'd0, 3'd1, 3'd2};
    else if (rd && !wr) legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    else                legal = 1'b0;
    size    = 1 << f3[1:0];
    aligned = ((int'(a[1:0]) % size) == 0);
    go      = legal && aligned;

    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    bus_ready = 1'($urandom); bus_rdata = $urandom;
    #1;
    check_eq("req_err", 32'(err), 32'(!go));
    check_eq("req_stall", 32'(stall), 32'(go));
    check_eq("req_valid", 32'(bus_valid), 32'd0);

    if (!go) begin
      @(posedge clk); #1;
      rdata_m = 32'h0;
      check_eq("err_rdata", rdata, rdata_m);
      check_eq("err_valid", 32'(bus_valid), 32'd0);
      mem_read = 1'b0; mem_write = 1'b0;
      return;
    end

    exp_be = 4'hF;
    exp_wd = wd;
    if (wr) begin
      if (size == 1) begin
        exp_be = 4'b0001 << a[1:0];
        exp_wd = 32'(wd[7:0]) * 32'h01010101;
      end else if (size == 2) begin
        exp_be = a[1] ? 4'b1100 : 4'b0011;
        exp_wd = 32'(wd[15:0]) * 32'h00010001;
      end
    end

    sh = rw >> (8 * a[1:0]);
    bb = sh[7:0];
    sh = rw >> (16 * a[1]);
    hh = sh[15:0];
    case (f3)
      3'd0, 3'd4: begin
        exp_rd = {24'h0, bb};
        if (!f3[2] && bb[7]) exp_rd = exp_rd - 32'h100;
      end
      3'd1, 3'd5: begin
        exp_rd = {16'h0, hh};
        if (!f3[2] && hh[15]) exp_rd = exp_rd - 32'h10000;
      end
      default: exp_rd = rw;
    endcase

    @(posedge clk);
    for (int k = 0; k <= dly; k++) begin
      #1;
      bus_ready = (k == dly);
      bus_rdata = (k == dly) ? rw : $urandom;
      #1;
      check_eq("req_valid", 32'(bus_valid), 32'd1);
      check_eq("req_stall", 32'(stall), 32'd1);
      check_eq("req_we", 32'(bus_we), 32'(wr));
      check_eq("req_addr", bus_addr, a & ~32'h3);
      check_eq("req_be", 32'(bus_be), 32'(exp_be));
      if (wr) check_eq("req_wdata", bus_wdata, exp_wd);
      @(posedge clk);
    end

    #1;
    bus_ready = 1'($urandom); bus_rdata = $urandom;
    #1;
    if (rd) rdata_m = exp_rd;
    check_eq("done_stall", 32'(stall), 32'd0);
    check_eq("done_err", 32'(err), 32'd0);
    check_eq("done_valid", 32'(bus_valid), 32'd0);
    check_eq("done_rdata", rdata, rdata_m);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic idle_cycle();
    mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'($urandom); addr = $urandom; bus_ready = 1'($urandom);
    #1;
    check_eq("idle_err", 32'(err), 32'd0);
    check_eq("idle_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    check_eq("idle_valid", 32'(bus_valid), 32'd0);
    check_eq("idle_rdata", rdata, rdata_m);
  endtask

  initial begin
    rst = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    addr = 32'h0; wdata = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(bus_valid), 32'd0);
    check_eq("rst_we", 32'(bus_we), 32'd0);
    check_eq("rst_addr", bus_addr, 32'h0);
    check_eq("rst_be", 32'(bus_be), 32'd0);
    check_eq("rst_wdata", bus_wdata, 32'h0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    access(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    access(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF0000, 1);
    access(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF0000, 0);
    access(1'b0, 1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0, 3);
    access(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0);
    access(1'b0, 1'b1, 3'd1, 32'h3, 32'h55667788, 32'h0, 0);
    access(1'b1, 1'b0, 3'd3, 32'h40, 32'h0, 32'h0, 0);
    access(1'b1, 1'b1, 3'd2, 32'h40, 32'h0, 32'h0, 0);
    access(1'b0, 1'b1, 3'd4, 32'h40, 32'h0, 32'h0, 0);
    idle_cycle();

    // Abort a transfer with reset while it waits for bus_ready.
    access(1'b1, 1'b0, 3'd5, 32'h22, 32'h0, 32'hC0DE8001, 0);
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2; addr = 32'h44; bus_ready = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_pre_valid", 32'(bus_valid), 32'd1);
    rst = 1'b0;
    #1;
    rdata_m = 32'h0;
    check_eq("abort_valid", 32'(bus_valid), 32'd0);
    check_eq("abort_addr", bus_addr, 32'h0);
    check_eq("abort_rdata", rdata, 32'h0);
    check_eq("abort_stall", 32'(stall), 32'd1);
    mem_read = 1'b0;
    #1;
    check_eq("abort_stall_idle", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_after_valid", 32'(bus_valid), 32'd0);
    access(1'b1, 1'b0, 3'd2, 32'h44, 32'h0, 32'h0BADF00D, 1);

    for (int i = 0; i < 200; i++) begin
      int sel;
      logic rd, wr;
      sel = $urandom_range(0, 11);
      rd = (sel == 0) || (sel >= 2 && sel <= 6);
      wr = (sel == 0) || (sel >= 7);
      if (sel == 1) idle_cycle();
      else access(rd, wr, 3'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
